// File: rtl/id_ex_fwd_stage_pkg.sv
// id_ex_fwd_stage_pkg: widths, aluop/alusel codes, opcode/funct constants and the instruction decoder
package id_ex_fwd_stage_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_NUM_FWD = 2;
  localparam int DEF_ALUOP_W = 8;
  localparam int DEF_ALUSEL_W = 3;
  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_AND = 8'h24,
    OP_OR  = 8'h25,
    OP_XOR = 8'h26,
    OP_NOR = 8'h27,
    OP_SLL = 8'h7c,
    OP_SRL = 8'h02,
    OP_SRA = 8'h03
  } aluop_e;
  typedef enum logic [2:0] {
    SEL_NOP   = 3'd0,
    SEL_LOGIC = 3'd1,
    SEL_SHIFT = 3'd2
  } alusel_e;
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_PREF    = 6'b110011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  typedef struct packed {
    aluop_e      aluop;
    alusel_e     alusel;
    logic        re1;
    logic        re2;
    logic        wreg;
    logic        invalid;
    logic [4:0]  wd;
    logic [31:0] imm;
  } dec_t;
  function automatic dec_t decode(logic [31:0] inst);
    dec_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    d = '0;
    d.invalid = 1'b1;
    case (op)
      OPC_SPECIAL:
        case (fn)
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV:
            if (inst[10:6] == 5'd0) begin
              d.aluop = fn == FN_AND ? OP_AND : fn == FN_OR ? OP_OR : fn == FN_XOR ? OP_XOR :
                        fn == FN_NOR ? OP_NOR : fn == FN_SLLV ? OP_SLL : fn == FN_SRLV ? OP_SRL : OP_SRA;
              d.alusel = fn[5] ? SEL_LOGIC : SEL_SHIFT;
              d.re1 = 1'b1;
              d.re2 = 1'b1;
              d.wreg = 1'b1;
              d.wd = inst[15:11];
              d.invalid = 1'b0;
            end
          FN_SLL, FN_SRL, FN_SRA:
            if (inst[25:21] == 5'd0) begin
              d.aluop = fn == FN_SLL ? OP_SLL : fn == FN_SRL ? OP_SRL : OP_SRA;
              d.alusel = SEL_SHIFT;
              d.re2 = 1'b1;
              d.wreg = 1'b1;
              d.wd = inst[15:11];
              d.imm = {27'd0, inst[10:6]};
              d.invalid = 1'b0;
            end
          FN_SYNC: d.invalid = 1'b0;
          default: ;
        endcase
      OPC_ORI, OPC_ANDI, OPC_XORI: begin
        d.aluop = op == OPC_ORI ? OP_OR : op == OPC_ANDI ? OP_AND : OP_XOR;
        d.alusel = SEL_LOGIC;
        d.re1 = 1'b1;
        d.wreg = 1'b1;
        d.wd = inst[20:16];
        d.imm = {16'd0, inst[15:0]};
        d.invalid = 1'b0;
      end
      OPC_LUI: begin
        d.aluop = OP_OR;
        d.alusel = SEL_LOGIC;
        d.wreg = 1'b1;
        d.wd = inst[20:16];
        d.imm = {inst[15:0], 16'd0};
        d.invalid = 1'b0;
      end
      OPC_PREF: d.invalid = 1'b0;
      default: ;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/id_ex_fwd_stage_if.sv
// id_ex_fwd_stage_if: if_id/regfile/forwarding/ctrl inputs and ID/EX outputs of the decode stage
interface id_ex_fwd_stage_if import id_ex_fwd_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int ALUOP_W = DEF_ALUOP_W,
  parameter int ALUSEL_W = DEF_ALUSEL_W
);
  logic                       stall_i;
  logic                       flush_i;
  logic                       inst_valid_i;
  logic [31:0]                pc_i;
  logic [31:0]                inst_i;
  logic [DATA_W-1:0]          reg1_data_i;
  logic [DATA_W-1:0]          reg2_data_i;
  logic [NUM_FWD-1:0]         fwd_wreg_i;
  logic [NUM_FWD-1:0]         fwd_load_i;
  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i;
  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i;
  logic                       reg1_read_o;
  logic                       reg2_read_o;
  logic [RADDR_W-1:0]         reg1_addr_o;
  logic [RADDR_W-1:0]         reg2_addr_o;
  logic                       stallreq_o;
  logic                       ex_valid_o;
  logic [31:0]                ex_pc_o;
  logic [ALUOP_W-1:0]         ex_aluop_o;
  logic [ALUSEL_W-1:0]        ex_alusel_o;
  logic [DATA_W-1:0]          ex_reg1_o;
  logic [DATA_W-1:0]          ex_reg2_o;
  logic [RADDR_W-1:0]         ex_wd_o;
  logic                       ex_wreg_o;
  logic                       ex_invalid_o;
  modport master (
    output stall_i, flush_i, inst_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i,
    input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
           ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
           ex_wd_o, ex_wreg_o, ex_invalid_o
  );
  modport slave (
    input  stall_i, flush_i, inst_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
           fwd_wreg_i, fwd_load_i, fwd_wd_i, fwd_wdata_i,
    output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
           ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
           ex_wd_o, ex_wreg_o, ex_invalid_o
  );
endinterface

// File: rtl/id_ex_fwd_stage_opnd_mux.sv
// id_opnd_mux: picks an operand from the youngest matching forward source, the regfile or the immediate
module id_opnd_mux #(
  parameter int DATA_W = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                       i_read,
  input  logic [RADDR_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]          i_reg_data,
  input  logic [DATA_W-1:0]          i_imm,
  input  logic [NUM_FWD-1:0]         i_fwd_wreg,
  input  logic [NUM_FWD-1:0]         i_fwd_load,
  input  logic [NUM_FWD*RADDR_W-1:0] i_fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0]  i_fwd_wdata,
  output logic [DATA_W-1:0]          o_opnd,
  output logic                       o_load_hit
);
  always_comb begin
    o_opnd = i_read ? (i_addr == '0 ? '0 : i_reg_data) : i_imm;
    o_load_hit = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--)
      if (i_read && i_addr != '0 && i_fwd_wreg[k] && i_fwd_wd[k*RADDR_W +: RADDR_W] == i_addr) begin
        o_opnd = i_fwd_wdata[k*DATA_W +: DATA_W];
        o_load_hit = i_fwd_load[k];
      end
  end
endmodule

// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage: logic/shift decode, forwarded operand select, load-use stall request and ID/EX register
module id_ex_fwd_stage import id_ex_fwd_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int ALUOP_W = DEF_ALUOP_W,
  parameter int ALUSEL_W = DEF_ALUSEL_W
) (
  input logic clk,
  input logic rst,
  id_ex_fwd_stage_if.slave bus
);
  dec_t                w_dec;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_opnd1;
  logic [DATA_W-1:0]   w_opnd2;
  logic                w_hit1;
  logic                w_hit2;
  logic                w_stallreq;
  logic                w_bubble;
  logic                r_valid;
  logic [31:0]         r_pc;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [RADDR_W-1:0]  r_wd;
  logic                r_wreg;
  logic                r_invalid;
  assign w_dec = decode(bus.inst_i);
  assign w_imm = DATA_W'(w_dec.imm);
  assign bus.reg1_read_o = w_dec.re1;
  assign bus.reg2_read_o = w_dec.re2;
  assign bus.reg1_addr_o = RADDR_W'(bus.inst_i[25:21]);
  assign bus.reg2_addr_o = RADDR_W'(bus.inst_i[20:16]);
  id_opnd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_opnd1 (
    .i_read(w_dec.re1), .i_addr(bus.reg1_addr_o), .i_reg_data(bus.reg1_data_i), .i_imm(w_imm),
    .i_fwd_wreg(bus.fwd_wreg_i), .i_fwd_load(bus.fwd_load_i), .i_fwd_wd(bus.fwd_wd_i),
    .i_fwd_wdata(bus.fwd_wdata_i), .o_opnd(w_opnd1), .o_load_hit(w_hit1)
  );
  id_opnd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_opnd2 (
    .i_read(w_dec.re2), .i_addr(bus.reg2_addr_o), .i_reg_data(bus.reg2_data_i), .i_imm(w_imm),
    .i_fwd_wreg(bus.fwd_wreg_i), .i_fwd_load(bus.fwd_load_i), .i_fwd_wd(bus.fwd_wd_i),
    .i_fwd_wdata(bus.fwd_wdata_i), .o_opnd(w_opnd2), .o_load_hit(w_hit2)
  );
  assign w_stallreq = bus.inst_valid_i & (w_hit1 | w_hit2);
  assign bus.stallreq_o = w_stallreq;
  assign w_bubble = rst | bus.flush_i | (~bus.stall_i & (w_stallreq | ~bus.inst_valid_i));
  always_ff @(posedge clk)
    if (w_bubble) begin
      r_valid <= 1'b0;
      r_pc <= '0;
      r_aluop <= '0;
      r_alusel <= '0;
      r_reg1 <= '0;
      r_reg2 <= '0;
      r_wd <= '0;
      r_wreg <= 1'b0;
      r_invalid <= 1'b0;
    end else if (!bus.stall_i) begin
      r_valid <= 1'b1;
      r_pc <= bus.pc_i;
      r_aluop <= ALUOP_W'(w_dec.aluop);
      r_alusel <= ALUSEL_W'(w_dec.alusel);
      r_reg1 <= w_opnd1;
      r_reg2 <= w_opnd2;
      r_wd <= RADDR_W'(w_dec.wd);
      r_wreg <= w_dec.wreg;
      r_invalid <= w_dec.invalid;
    end
  assign bus.ex_valid_o = r_valid;
  assign bus.ex_pc_o = r_pc;
  assign bus.ex_aluop_o = r_aluop;
  assign bus.ex_alusel_o = r_alusel;
  assign bus.ex_reg1_o = r_reg1;
  assign bus.ex_reg2_o = r_reg2;
  assign bus.ex_wd_o = r_wd;
  assign bus.ex_wreg_o = r_wreg;
  assign bus.ex_invalid_o = r_invalid;
endmodule
